// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART result packetizer.
// Optional checksum byte is selected by the UART_PKT_CHECKSUM_EN macro.
package uart_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    WAIT = 2'b10
  } pkt_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h55;

  localparam int         PKT_LEN_CSUM   = 7;
  localparam int         PKT_LEN_PLAIN  = 6;
  localparam logic [2:0] LAST_IDX_CSUM  = 3'd6;
  localparam logic [2:0] LAST_IDX_PLAIN = 3'd5;

`ifdef UART_PKT_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = LAST_IDX_CSUM;

  // Entry layout is {tag, word}; the sync byte is not part of the sum.
  function automatic logic [7:0] pkt_checksum(input logic [39:0] entry);
    return entry[39:32] + entry[7:0] + entry[15:8] + entry[23:16] + entry[31:24];
  endfunction
`else
  localparam logic [2:0] LAST_IDX = LAST_IDX_PLAIN;
`endif

endpackage

// File: rtl/uart_tx_packetizer_fifo.sv
// pkt_word_fifo: small synchronous FIFO holding {tag, word} entries.
// Head entry is read combinationally; storage is not reset, only the pointers.
module pkt_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic             i_Clock,
  input  logic             i_Rst_L,
  input  logic             i_Push,
  input  logic [WIDTH-1:0] i_Data,
  input  logic             i_Pop,
  output logic [WIDTH-1:0] o_Head,
  output logic             o_Full,
  output logic             o_Empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign o_Full  = (count == (AW+1)'(DEPTH));
  assign o_Empty = (count == '0);
  assign push_ok = i_Push && !o_Full;
  assign pop_ok  = i_Pop && !o_Empty;
  assign o_Head  = mem[rd_ptr];

  always_ff @(posedge i_Clock) begin
    if (push_ok) mem[wr_ptr] <= i_Data;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_packetizer.sv
// Frames {tag, word} results into byte packets for uart_tx (SYNC, tag, word LSB first).
// Define UART_PKT_CHECKSUM_EN to append an 8-bit sum of tag and payload bytes.
//
// state | meaning
// IDLE  | no packet on the line; pops the FIFO head when one is waiting
// SEND  | one-cycle byte request to uart_tx
// WAIT  | byte held until uart_tx reports done
module uart_tx_packetizer
  import uart_pkt_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic        i_Clock,
  input  logic        i_Rst_L,
  input  logic        i_Word_DV,
  input  logic [31:0] i_Word,
  input  logic [7:0]  i_Tag,
  output logic        o_Word_Ready,
  output logic        o_Overflow,
  output logic        o_TX_DV,
  output logic [7:0]  o_TX_Byte,
  input  logic        i_TX_Done,
  output logic        o_Busy
);

  pkt_state_t  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [39:0] pkt_q, pkt_d;
  logic [39:0] fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        overflow_q;
  logic [7:0]  cur_byte;

  pkt_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (40)
  ) u_fifo (
    .i_Clock (i_Clock),
    .i_Rst_L (i_Rst_L),
    .i_Push  (i_Word_DV),
    .i_Data  ({i_Tag, i_Word}),
    .i_Pop   (pop),
    .o_Head  (fifo_head),
    .o_Full  (fifo_full),
    .o_Empty (fifo_empty)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pkt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pkt_q      <= pkt_d;
      overflow_q <= i_Word_DV && fifo_full;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pkt_d   = pkt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          pkt_d   = fifo_head;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (i_TX_Done) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte is forced to zero in IDLE so the reset value holds between packets.
  always_comb begin
    cur_byte = 8'h00;
    if (state_q != IDLE) begin
      case (idx_q)
        3'd0: cur_byte = SYNC_BYTE;
        3'd1: cur_byte = pkt_q[39:32];
        3'd2: cur_byte = pkt_q[7:0];
        3'd3: cur_byte = pkt_q[15:8];
        3'd4: cur_byte = pkt_q[23:16];
        3'd5: cur_byte = pkt_q[31:24];
`ifdef UART_PKT_CHECKSUM_EN
        3'd6: cur_byte = pkt_checksum(pkt_q);
`endif
        default: cur_byte = 8'h00;
      endcase
    end
  end

  assign o_TX_DV      = (state_q == SEND);
  assign o_TX_Byte    = cur_byte;
  assign o_Overflow   = overflow_q;
  assign o_Word_Ready = !fifo_full;
  assign o_Busy       = (state_q != IDLE) || !fifo_empty;

endmodule
